// File: rtl/vga_timing_pkg.sv
// Shared XGA 1024x768@60 timing constants, counter widths and the raster payload type.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 136;
  localparam int unsigned H_BP     = 160;
  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 29;

  localparam int unsigned H_CNT_W  = 11;
  localparam int unsigned V_CNT_W  = 10;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned FRAME_W  = 8;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  typedef struct packed {
    logic               visible;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               line_start;
    logic               frame_start;
  } raster_t;

  localparam raster_t RASTER_RESET = '{
    visible:     1'b1,
    pix_x:       '0,
    pix_y:       '0,
    line_start:  1'b1,
    frame_start: 1'b1
  };

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrap counter with increment-enable, registered sync window flag
// and next-count active-region flag.
module timing_axis_counter #(
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned ACTIVE = 1024,
  parameter int unsigned FP     = 24,
  parameter int unsigned SYNC   = 136,
  parameter int unsigned BP     = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_next_c_o,
  output logic             wrap_c_o,
  output logic             active_next_c_o,
  output logic             sync_o
);
  import vga_timing_pkg::*;

  localparam int unsigned     TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W:0]   ACTIVE_END = (CNT_W + 1)'(ACTIVE);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;

  // Flags are derived from the next count so they line up with it after the edge.
  always_comb begin
    count_d  = count_q;
    wrap_c_o = 1'b0;
    if (inc_i) begin
      if (count_q == LAST) begin
        count_d  = '0;
        wrap_c_o = 1'b1;
      end else begin
        count_d  = count_q + CNT_W'(1);
      end
    end
    sync_d          = (count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST);
    active_next_c_o = {1'b0, count_d} < ACTIVE_END;
    count_next_c_o  = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running XGA raster timing generator: syncs, visible flag, coordinates, strobes.
// Optional frame counter built only when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable_i,
  input  logic                                polarity_i,
  output logic                                hsync_o,
  output logic                                vsync_o,
  output logic                                visible_o,
  output logic [vga_timing_pkg::COORD_W-1:0]  pix_x_o,
  output logic [vga_timing_pkg::COORD_W-1:0]  pix_y_o,
  output logic                                line_start_o,
  output logic                                frame_start_o,
  output logic [vga_timing_pkg::FRAME_W-1:0]  frame_count_o
);
  import vga_timing_pkg::*;

  localparam int unsigned H_SPAN = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_SPAN = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE > (1 << COORD_W) || V_ACTIVE > (1 << COORD_W) ||
      H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      H_SPAN > (1 << H_CNT_W) || V_SPAN > (1 << V_CNT_W)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [H_CNT_W-1:0] h_next_c;
  logic [V_CNT_W-1:0] v_next_c;
  logic               h_wrap_c, v_wrap_c;
  logic               h_act_next_c, v_act_next_c;
  logic               h_sync, v_sync;
  logic               v_inc_c;

  assign v_inc_c = enable_i & h_wrap_c;

  timing_axis_counter #(
    .CNT_W (H_CNT_W),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP)
  ) u_h_axis (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc_i          (enable_i),
    .count_next_c_o (h_next_c),
    .wrap_c_o       (h_wrap_c),
    .active_next_c_o(h_act_next_c),
    .sync_o         (h_sync)
  );

  timing_axis_counter #(
    .CNT_W (V_CNT_W),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP)
  ) u_v_axis (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc_i          (v_inc_c),
    .count_next_c_o (v_next_c),
    .wrap_c_o       (v_wrap_c),
    .active_next_c_o(v_act_next_c),
    .sync_o         (v_sync)
  );

  raster_t raster_q, raster_d;

  // A wrap is the only enabled way into h==0 / (0,0), so it doubles as the strobe source.
  always_comb begin
    raster_d = raster_q;
    if (enable_i) begin
      raster_d.visible     = h_act_next_c & v_act_next_c;
      raster_d.pix_x       = raster_d.visible ? COORD_W'(h_next_c) : '0;
      raster_d.pix_y       = raster_d.visible ? COORD_W'(v_next_c) : '0;
      raster_d.line_start  = h_wrap_c;
      raster_d.frame_start = v_wrap_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raster_q <= RASTER_RESET;
    end else begin
      raster_q <= raster_d;
    end
  end

  assign visible_o     = raster_q.visible;
  assign pix_x_o       = raster_q.pix_x;
  assign pix_y_o       = raster_q.pix_y;
  assign line_start_o  = raster_q.line_start;
  assign frame_start_o = raster_q.frame_start;

  // Polarity is applied after the flops so a change is visible in the same cycle.
  assign hsync_o = ~(h_sync ^ polarity_i);
  assign vsync_o = ~(v_sync ^ polarity_i);

`ifdef VGA_FRAME_COUNTER_EN
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap_c) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count_o = frame_cnt_q;
`else
  assign frame_count_o = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: an XGA instance for line-level timing and a reduced-geometry
// instance (12x9 raster) for frame, polarity, freeze and mid-frame reset behaviour.
module tb_vga_timing_gen;

  localparam int SH_ACT = 6, SH_FP = 1, SH_SYNC = 2, SH_BP = 3, SH_TOT = 12;
  localparam int SV_ACT = 4, SV_FP = 1, SV_SYNC = 2, SV_BP = 2, SV_TOT = 9;

  logic       clk = 1'b0;
  logic       rst_n, enable, polarity;
  logic       x_hs, x_vs, x_vis, x_ls, x_fs;
  logic [9:0] x_px, x_py;
  logic [7:0] x_fc;
  logic       s_hs, s_vs, s_vis, s_ls, s_fs;
  logic [9:0] s_px, s_py;
  logic [7:0] s_fc;

  always #5 clk = ~clk;

  vga_timing_gen u_xga (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .polarity_i(polarity),
    .hsync_o(x_hs), .vsync_o(x_vs), .visible_o(x_vis), .pix_x_o(x_px), .pix_y_o(x_py),
    .line_start_o(x_ls), .frame_start_o(x_fs), .frame_count_o(x_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .polarity_i(polarity),
    .hsync_o(s_hs), .vsync_o(s_vs), .visible_o(s_vis), .pix_x_o(s_px), .pix_y_o(s_py),
    .line_start_o(s_ls), .frame_start_o(s_fs), .frame_count_o(s_fc)
  );

  int tests = 0;
  int fails = 0;
  int mh, mv, mframes;
  int t;

  typedef struct {
    int t;
    bit vis, hs, ls, fs;
    int px, py;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_fc();
`ifdef VGA_FRAME_COUNTER_EN
    return mframes % 256;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mframes = 0;
  endtask

  task automatic model_adv();
    if (mh == SH_TOT - 1) begin
      mh = 0;
      if (mv == SV_TOT - 1) begin
        mv = 0;
        mframes++;
      end else begin
        mv++;
      end
    end else begin
      mh++;
    end
  endtask

  task automatic check_small();
    bit vis, ah, av;
    vis = (mh < SH_ACT) && (mv < SV_ACT);
    ah  = (mh >= SH_ACT + SH_FP) && (mh <= SH_ACT + SH_FP + SH_SYNC - 1);
    av  = (mv >= SV_ACT + SV_FP) && (mv <= SV_ACT + SV_FP + SV_SYNC - 1);
    chk("s_visible", int'(s_vis), int'(vis));
    chk("s_hsync", int'(s_hs), int'(polarity ? ah : !ah));
    chk("s_vsync", int'(s_vs), int'(polarity ? av : !av));
    chk("s_pix_x", int'(s_px), vis ? mh : 0);
    chk("s_pix_y", int'(s_py), vis ? mv : 0);
    chk("s_line_start", int'(s_ls), int'(mh == 0));
    chk("s_frame_start", int'(s_fs), int'(mh == 0 && mv == 0));
    chk("s_frame_count", int'(s_fc), exp_fc());
  endtask

  task automatic step();
    logic en, rs;
    en = enable;
    rs = rst_n;
    @(negedge clk);
    if (!rs) model_reset();
    else if (en) model_adv();
    t++;
    check_small();
  endtask

  task automatic run_until(input int h, input int v, input int f, input int budget, input string nm);
    int k;
    k = 0;
    while (!(mh == h && mv == v && (f < 0 || mframes == f)) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      tests++;
      fails++;
      $display("FAIL %s: position (%0d,%0d) not reached within %0d cycles", nm, h, v, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt, vs_cnt, fs_cnt;

    // Hand-computed XGA line-0/line-1 expectations at polarity 1.
    vt[0]  = '{0,    1, 0, 1, 1, 0,    0};
    vt[1]  = '{1,    1, 0, 0, 0, 1,    0};
    vt[2]  = '{2,    1, 0, 0, 0, 2,    0};
    vt[3]  = '{1023, 1, 0, 0, 0, 1023, 0};
    vt[4]  = '{1024, 0, 0, 0, 0, 0,    0};
    vt[5]  = '{1047, 0, 0, 0, 0, 0,    0};
    vt[6]  = '{1048, 0, 1, 0, 0, 0,    0};
    vt[7]  = '{1183, 0, 1, 0, 0, 0,    0};
    vt[8]  = '{1184, 0, 0, 0, 0, 0,    0};
    vt[9]  = '{1343, 0, 0, 0, 0, 0,    0};
    vt[10] = '{1344, 1, 0, 1, 0, 0,    1};
    vt[11] = '{1345, 1, 0, 0, 0, 1,    1};

    rst_n = 1'b0; enable = 1'b1; polarity = 1'b1; t = 0;
    model_reset();
    repeat (3) @(negedge clk);

    check_small();
    chk("x_rst_visible", int'(x_vis), 1);
    chk("x_rst_hsync", int'(x_hs), 0);
    chk("x_rst_vsync", int'(x_vs), 0);
    chk("x_rst_line_start", int'(x_ls), 1);
    chk("x_rst_frame_start", int'(x_fs), 1);
    chk("x_rst_pix_x", int'(x_px), 0);
    chk("x_rst_frame_count", int'(x_fc), 0);

    rst_n = 1'b1;
    t = 0;
    hs_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      while (t < vt[i].t) begin
        step();
        if (t <= 1343) hs_cnt += int'(x_hs);
      end
      chk($sformatf("x_visible@%0d", vt[i].t), int'(x_vis), int'(vt[i].vis));
      chk($sformatf("x_hsync@%0d", vt[i].t), int'(x_hs), int'(vt[i].hs));
      chk($sformatf("x_vsync@%0d", vt[i].t), int'(x_vs), 0);
      chk($sformatf("x_line_start@%0d", vt[i].t), int'(x_ls), int'(vt[i].ls));
      chk($sformatf("x_frame_start@%0d", vt[i].t), int'(x_fs), int'(vt[i].fs));
      chk($sformatf("x_pix_x@%0d", vt[i].t), int'(x_px), vt[i].px);
      chk($sformatf("x_pix_y@%0d", vt[i].t), int'(x_py), vt[i].py);
      chk($sformatf("x_frame_count@%0d", vt[i].t), int'(x_fc), 0);
    end
    chk("x_hsync_width", hs_cnt, 136);

    // One full reduced frame: vsync width and frame period.
    run_until(0, 0, -1, 200, "frame_align");
    vs_cnt = 0;
    fs_cnt = 0;
    for (int i = 1; i <= SH_TOT * SV_TOT; i++) begin
      step();
      vs_cnt += int'(s_vs);
      fs_cnt += int'(s_fs);
    end
    chk("s_vsync_cycles", vs_cnt, SV_SYNC * SH_TOT);
    chk("s_frame_pulses", fs_cnt, 1);
    chk("s_frame_start_at_period", int'(s_fs), 1);
    chk("s_frame_count_after_frame", int'(s_fc), exp_fc());

    // Polarity flip mid-line outside the sync windows.
    run_until(3, 0, -1, 200, "pol_pos");
    polarity = 1'b0;
    #1;
    chk("pol_hsync_idle", int'(s_hs), 1);
    chk("pol_vsync_idle", int'(s_vs), 1);
    chk("pol_pix_x_kept", int'(s_px), 3);
    run_until(7, 0, -1, 200, "pol_hsync_pos");
    chk("pol_hsync_active", int'(s_hs), 0);
    run_until(0, 5, -1, 200, "pol_vsync_pos");
    chk("pol_vsync_active", int'(s_vs), 0);
    polarity = 1'b1;
    #1;
    chk("pol_restore_vsync", int'(s_vs), 1);
    chk("pol_restore_hsync", int'(s_hs), 0);

    // Freeze at (3,2) for 40 cycles, then resume.
    run_until(3, 2, -1, 200, "freeze_pos");
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("freeze_pix_x", int'(s_px), 3);
      chk("freeze_pix_y", int'(s_py), 2);
    end
    enable = 1'b1;
    step();
    chk("resume_pix_x", int'(s_px), 4);
    chk("resume_pix_y", int'(s_py), 2);

    // Asynchronous reset inside both sync windows of frame 255.
    run_until(8, 6, 255, 30000, "rst_pos");
    chk("pre_rst_frame_count", int'(s_fc), exp_fc());
    chk("pre_rst_hsync", int'(s_hs), 1);
    chk("pre_rst_vsync", int'(s_vs), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_small();
    chk("x_midrst_visible", int'(x_vis), 1);
    chk("x_midrst_pix_x", int'(x_px), 0);
    chk("x_midrst_line_start", int'(x_ls), 1);
    chk("x_midrst_frame_start", int'(x_fs), 1);
    chk("x_midrst_hsync", int'(x_hs), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_pix_x", int'(s_px), 1);
    chk("post_rst_line_start", int'(s_ls), 0);
    chk("post_rst_frame_start", int'(s_fs), 0);
    chk("x_post_rst_pix_x", int'(x_px), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
